// File: rtl/sipo_deshifter.sv
// sipo_deshifter: serial-in/parallel-out receiver with single-entry valid/ready output slot
module sipo_deshifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             msb_first,
  input  logic             flush,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             ovr_sticky,
  output logic [CNT_W-1:0] bit_cnt
);
  logic [WIDTH-1:0] sh, sh_nx;
  logic             ord_q, ord, accept, done, take, drop;
  // bit order is taken from msb_first only on the first bit of a word
  always_comb begin
    accept = ser_valid & ~flush;
    ord    = (bit_cnt == '0) ? msb_first : ord_q;
    sh_nx  = ord ? {sh[WIDTH-2:0], ser_in} : {ser_in, sh[WIDTH-1:1]};
    done   = accept & (bit_cnt == CNT_W'(WIDTH - 1));
    take   = out_valid & out_ready;
    drop   = done & out_valid & ~out_ready;
  end
  // shift register, bit counter and latched order; flush beats a same-cycle bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh      <= '0;
      bit_cnt <= '0;
      ord_q   <= 1'b0;
    end else if (flush) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sh      <= sh_nx;
      bit_cnt <= done ? '0 : bit_cnt + CNT_W'(1);
      ord_q   <= ord;
    end
  end
  // output slot: load on completion if free or draining, otherwise drop and flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_out    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      ovr_sticky <= 1'b0;
    end else begin
      if (done & (~out_valid | out_ready)) begin
        par_out   <= sh_nx;
        out_valid <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end
      overrun    <= drop;
      ovr_sticky <= drop | (ovr_sticky & ~ovr_clr);
    end
  end
endmodule

// File: tb/tb_sipo_deshifter.sv
// tb_sipo_deshifter: directed and random stimulus against a bit-queue reference model
module tb_sipo_deshifter;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst, ser_in, ser_valid, msb_first, flush, ovr_clr, out_ready;
  logic [W-1:0] par_out;
  logic         out_valid, overrun, ovr_sticky;
  logic [2:0]   bit_cnt;
  int           checks = 0;
  int           failures = 0;
  int           bits[$];
  logic         m_ord, m_valid, m_ovr, m_sticky;
  logic [W-1:0] m_par;

  sipo_deshifter #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .msb_first(msb_first), .flush(flush), .ovr_clr(ovr_clr),
    .par_out(par_out), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .ovr_sticky(ovr_sticky), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    m_ord = 0; m_valid = 0; m_ovr = 0; m_sticky = 0; m_par = '0;
  endtask

  task automatic model_update();
    logic         done;
    logic [W-1:0] word;
    done = 0;
    word = '0;
    if (flush) bits.delete();
    else if (ser_valid) begin
      if (bits.size() == 0) m_ord = msb_first;
      bits.push_back(int'(ser_in));
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++)
          if (m_ord) word[W-1-i] = bits[i][0];
          else word[i] = bits[i][0];
        done = 1;
        bits.delete();
      end
    end
    m_ovr = done && m_valid && !out_ready;
    if (done && (!m_valid || out_ready)) begin
      m_par = word;
      m_valid = 1;
    end else if (m_valid && out_ready) m_valid = 0;
    m_sticky = m_ovr || (m_sticky && !ovr_clr);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_update();
    @(negedge clk);
    chk("par_out", par_out, m_par);
    chk("out_valid", out_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("ovr_sticky", ovr_sticky, m_sticky);
    chk("bit_cnt", bit_cnt, bits.size());
  endtask

  task automatic drv(input logic si, input logic sv, input logic msb, input logic fl,
                     input logic oc, input logic rdy);
    ser_in = si; ser_valid = sv; msb_first = msb; flush = fl; ovr_clr = oc; out_ready = rdy;
    step();
  endtask

  task automatic send(input logic [W-1:0] w, input logic msb, input logic rdy);
    for (int i = 0; i < W; i++) drv(msb ? w[W-1-i] : w[i], 1, msb, 0, 0, rdy);
  endtask

  initial begin
    rst = 0;
    model_reset();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 1, 1, 0, 0, 0);
    chk("reset_par", par_out, 0);
    chk("reset_cnt", bit_cnt, 0);
    rst = 1;
    drv(0, 0, 0, 0, 0, 1);
    // back-to-back MSB-first
    send(8'hA5, 1, 1);
    chk("b2b_a5", par_out, 8'hA5);
    chk("b2b_a5_v", out_valid, 1);
    send(8'h3C, 1, 1);
    chk("b2b_3c", par_out, 8'h3C);
    chk("b2b_ovr", ovr_sticky, 0);
    drv(0, 0, 0, 0, 0, 1);
    // LSB-first with a 3-cycle gap
    for (int i = 0; i < 4; i++) drv(i == 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 1, 0, 0, 1);
      chk("gap_cnt", bit_cnt, 4);
    end
    for (int i = 4; i < 8; i++) drv(i == 7, 1, 1, 0, 0, 1);
    chk("lsb_81", par_out, 8'h81);
    drv(0, 0, 0, 0, 0, 1);
    // overrun
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_keep", par_out, 8'h11);
    drv(0, 0, 0, 0, 0, 0);
    chk("ovr_one", overrun, 0);
    chk("ovr_stk", ovr_sticky, 1);
    drv(0, 0, 0, 0, 1, 0);
    chk("ovr_clr", ovr_sticky, 0);
    drv(0, 0, 0, 0, 0, 1);
    chk("ovr_drain", out_valid, 0);
    // handshake and completion in the same cycle
    send(8'h11, 1, 0);
    for (int i = 0; i < W; i++) drv(8'h22 >> (W-1-i), 1, 1, 0, 0, i == W-1);
    chk("sim_par", par_out, 8'h22);
    chk("sim_v", out_valid, 1);
    chk("sim_ovr", overrun, 0);
    drv(0, 0, 0, 0, 0, 1);
    // flush and mid-word order change
    for (int i = 0; i < 5; i++) drv(1, 1, 0, 0, 0, 1);
    drv(1, 1, 1, 1, 0, 1);
    chk("flush_cnt", bit_cnt, 0);
    for (int i = 0; i < W; i++) drv(8'hF0 >> (W-1-i), 1, i < 2, 0, 0, 1);
    chk("flush_f0", par_out, 8'hF0);
    // async reset mid-word
    send(8'h5A, 0, 0);
    for (int i = 0; i < 3; i++) drv(1, 1, 1, 0, 0, 0);
    #2 rst = 0;
    #1;
    chk("arst_par", par_out, 0);
    chk("arst_v", out_valid, 0);
    chk("arst_cnt", bit_cnt, 0);
    chk("arst_stk", ovr_sticky, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    send(8'hC3, 1, 1);
    chk("arst_c3", par_out, 8'hC3);
    // random
    for (int n = 0; n < 3000; n++)
      drv($urandom_range(1), $urandom_range(3) != 0, $urandom_range(1),
          $urandom_range(31) == 0, $urandom_range(9) == 0, $urandom_range(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
